// File: rtl/ordenador_pkg.sv
// rtl/ordenador_pkg.sv - shared state encoding and default sizing for the bubble sorter
package ordenador_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/comparador_troca.sv
// rtl/comparador_troca.sv - combinational unsigned compare-and-swap, larger value to maior
module comparador_troca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] maior,
    output logic [WIDTH-1:0] menor,
    output logic             troca
);

    // Strict compare keeps equal values in place, which makes the sort stable.
    assign troca = (a < b);
    assign maior = troca ? b : a;
    assign menor = troca ? a : b;

endmodule

// File: rtl/ordenador_bolha.sv
// rtl/ordenador_bolha.sv - frame capture, in-place bubble sort, largest-first drain
module ordenador_bolha
    import ordenador_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int WIDTH = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(N - 2);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic [WIDTH-1:0] buf_q [N];
    logic [WIDTH-1:0] buf_d [N];

    logic [IDX_W-1:0] j_nxt;
    logic [IDX_W-1:0] j_last;
    logic [WIDTH-1:0] cmp_maior;
    logic [WIDTH-1:0] cmp_menor;
    logic             cmp_troca;

    assign j_nxt  = j_q + 1'b1;
    assign j_last = PASS_LAST - pass_q;

    comparador_troca #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a    (buf_q[j_q]),
        .b    (buf_q[j_nxt]),
        .maior(cmp_maior),
        .menor(cmp_menor),
        .troca(cmp_troca)
    );

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        pass_d   = pass_q;
        j_d      = j_q;
        buf_d    = buf_q;

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    buf_d[wr_idx_q] = in_data;
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d = '0;
                        pass_d   = '0;
                        j_d      = '0;
                        state_d  = SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end

            SORT: begin
                if (cmp_troca) begin
                    buf_d[j_q]   = cmp_maior;
                    buf_d[j_nxt] = cmp_menor;
                end
                // Each pass shrinks by one: the minimum settles at the tail.
                if (j_q == j_last) begin
                    j_d = '0;
                    if (pass_q == PASS_LAST) begin
                        pass_d   = '0;
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    j_d = j_nxt;
                end
            end

            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
            j_q      <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
            j_q      <= j_d;
            buf_q    <= buf_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == SORT);
    assign out_data  = buf_q[rd_idx_q];

endmodule

// File: tb/tb_ordenador_bolha.sv
// tb/tb_ordenador_bolha.sv - directed vector bench for ordenador_bolha
module tb_ordenador_bolha;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [7:0] din  [4];
        logic [7:0] dout [4];
        int         stall_at;
        bit         junk;
    } vec_t;

    vec_t vecs [5];

    ordenador_bolha #(
        .N(4),
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int k,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input int stall, input bit junk);
        vecs[k].din[0]  = a0; vecs[k].din[1]  = a1;
        vecs[k].din[2]  = a2; vecs[k].din[3]  = a3;
        vecs[k].dout[0] = e0; vecs[k].dout[1] = e1;
        vecs[k].dout[2] = e2; vecs[k].dout[3] = e3;
        vecs[k].stall_at = stall;
        vecs[k].junk     = junk;
    endtask

    // Loads 4 elements, then measures SORT length and the first out_valid cycle.
    task automatic load_and_sort(input int k);
        int busy_cnt;
        for (int i = 0; i < 4; i++) begin
            check("in_ready_load", int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = vecs[k].din[i];
            step();
        end
        if (vecs[k].junk) begin
            in_data = 8'hAA;
        end else begin
            in_valid = 1'b0;
        end
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            if (vecs[k].junk) check("in_ready_sort", int'(in_ready), 0);
            step();
        end
        check("sort_cycles", busy_cnt, 6);
        check("first_out_valid", int'(out_valid), 1);
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 4; i++) begin
            if (i == vecs[k].stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_data", int'(out_data), int'(vecs[k].dout[i]));
                    step();
                end
            end
            out_ready = 1'b1;
            check("out_valid", int'(out_valid), 1);
            check("out_data", int'(out_data), int'(vecs[k].dout[i]));
            if (vecs[k].junk) check("in_ready_drain", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("back_to_load_ready", int'(in_ready), 1);
        check("back_to_load_valid", int'(out_valid), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        set_vec(0, 8'd4, 8'd5, 8'd3, 8'd1, 8'd5, 8'd4, 8'd3, 8'd1, -1, 1'b0);
        set_vec(1, 8'd7, 8'd7, 8'd2, 8'd7, 8'd7, 8'd7, 8'd7, 8'd2, -1, 1'b0);
        set_vec(2, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h80, 8'h7F, 8'h00, -1, 1'b0);
        set_vec(3, 8'd9, 8'd8, 8'd6, 8'd1, 8'd9, 8'd8, 8'd6, 8'd1, 2, 1'b0);
        set_vec(4, 8'd3, 8'd10, 8'd20, 8'd15, 8'd20, 8'd15, 8'd10, 8'd3, -1, 1'b1);

        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_data", int'(out_data), 0);

        for (int k = 0; k < 5; k++) begin
            load_and_sort(k);
            drain(k);
        end

        // Reset in the middle of SORT abandons the frame.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'd50 + 8'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("midsort_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_data", int'(out_data), 0);

        set_vec(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, -1, 1'b0);
        load_and_sort(0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ordenador_bolha.md
# ordenador_bolha

Sequential sorter controller: captures a frame of N unsigned bytes over a valid/ready input, then sorts them in place with bubble-sort passes. Every comparison goes through a single shared compare-and-swap unit, and the block issues exactly one comparison per clock. The sorted frame streams out largest-first over a valid/ready output. It sits between a byte producer and any consumer that needs ranked (max-first) data.

## Interface
Parameters:
- N, 4, frame length (≥2)
- WIDTH, 8, data width (unsigned)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- in_valid  in  1  producer has in_data
- in_data  in  WIDTH  frame element
- in_ready  out  1  block accepts in_data; high only in LOAD
- out_valid  out  1  out_data valid; high only in DRAIN
- out_data  out  WIDTH  sorted element, largest first
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high in SORT

## Operation
- States: LOAD → SORT → DRAIN → LOAD.
- **LOAD:**
  - in_ready=1. Each handshake (in_valid&in_ready) writes buf[wr_idx] and increments wr_idx.
  - On the Nth handshake: wr_idx←0, state→SORT, pass←0, j←0.
- **SORT:**
  - Each cycle, one compare-and-swap on buf[j], buf[j+1]: buf[j]←max, buf[j+1]←min.
  - Compare is unsigned and strict (buf[j] < buf[j+1] swaps). Equal values never swap, so the sort is stable.
  - j runs 0..N-2-pass. At the end of a pass: pass++, j←0.
  - When pass reaches N-1 (after the final compare), state→DRAIN, rd_idx←0.
  - No early exit: SORT always lasts exactly N(N-1)/2 cycles (6 for N=4).
- **DRAIN:**
  - out_valid=1, out_data=buf[rd_idx].
  - Each out_valid&out_ready handshake increments rd_idx.
  - The Nth handshake sends state→LOAD with rd_idx←0.
  - out_data holds steady while out_ready=0.
- in_valid outside LOAD is ignored. out_ready outside DRAIN is ignored.
- **Reset:**
  - Synchronous, any cycle, including mid-SORT or mid-DRAIN. Abandons the frame.
  - State←LOAD; wr_idx, rd_idx, pass, j←0; buf entries←0.
  - Outputs after the reset edge: in_ready=1, out_valid=0, out_data=0, busy=0.
- Index counters are $clog2(N) bits and never wrap past N-1. Terminal compares use ==N-1 / ==N-2-pass.

## Timing
- in_ready, out_valid and busy decode directly from the registered state, with no combinational path from in_valid/out_ready.
- out_data is a mux on buf[rd_idx], registered-source only.
- Last input handshake at cycle t:
  - busy=1 in cycles t+1 .. t+N(N-1)/2.
  - First out_valid in cycle t+N(N-1)/2+1 (t+7 for N=4).
- Throughput with no backpressure: one frame per N + N(N-1)/2 + N cycles (14 for N=4).
- in_ready rises the cycle after the last output handshake. The block can accept a new element that same cycle.

## Structure
- Package ordenador_pkg holds:
  - state enum {LOAD, SORT, DRAIN};
  - default N/WIDTH constants.
- Sub-module comparador_troca (combinational): inputs a, b [WIDTH]; outputs maior, menor, troca (=a<b).
  - Exactly one instance.
  - Its operands come from buf[j], buf[j+1].
- All other logic (FSM, counters, buffer) lives in ordenador_bolha.

## Test plan
- Load 4,5,3,1 with no stalls → outputs 5,4,3,1. First out_valid 7 cycles after the last input handshake; busy high for 6 cycles.
- Load 7,7,2,7 → outputs 7,7,7,2. Load 0x00,0xFF,0x80,0x7F → outputs 0xFF,0x80,0x7F,0x00 (unsigned compare).
- Already sorted 9,8,6,1 → outputs 9,8,6,1, and SORT still lasts exactly 6 cycles.
- Backpressure: out_ready low for 3 cycles at element 2 → out_data stays at that element and out_valid stays high; all 4 values delivered once, in order.
- Drive in_valid=1 with 0xAA throughout SORT and DRAIN → in_ready=0, no capture, output frame unchanged.
- Assert rst for 1 cycle mid-SORT → next cycle in_ready=1, out_valid=0, busy=0. New frame 1,2,3,4 → outputs 4,3,2,1 with no stale data.
